pwr_en_sequencer: RTL
=====================

// Module: pwr_en_sequencer
// PURPOSE
//  Drives the per-module power-enable vector into the user DUT array and consumes its registered dummy outputs.
//  Steps through a selectable enable pattern, holding each step for a programmable dwell time.
//  Compacts the returned dummy bits into a 32-bit MISR signature, so DUT logic stays live and results are checkable.
//  Sits between the measurement control logic (start/mode/dwell) and the user DUT array, on clk100m.
// PARAMETERS
//  NUM_MODULES    32  number of DUT slots; legal 1..32.
//  DWELL_W        32  width of dwell_cycles and of the dwell counter.
//  SETTLE_CYCLES  4   cycles after each pattern change before MISR capture (covers the DUT array's 2-register sandwich).
// PORTS
//  clk100m       in   1            sole clock.
//  rst           in   1            synchronous, active-high reset.
//  start         in   1            1-cycle request; sampled only in IDLE.
//  mode          in   2            0=ramp (thermometer), 1=walking-one, 2=all-on, 3=all-off; latched on start.
//  dwell_cycles  in   DWELL_W      MISR-capture cycles per step; latched on start; 0 is treated as 1.
//  pwr_en_out    out  NUM_MODULES  registered enable vector to the DUT array.
//  dummy_in      in   NUM_MODULES  registered dummy outputs from the DUT array.
//  busy          out  1            high from the cycle after an accepted start until the done cycle.
//  done          out  1            1-cycle pulse at sequence end.
//  step_idx      out  6            current step number, 0-based.
//  signature     out  32           MISR state; held after done until the next accepted start.
// BEHAVIOUR
//  Reset values: pwr_en_out=0, busy=0, done=0, step_idx=0, signature=32'hFFFF_FFFF, FSM=IDLE, counters=0.
//  FSM states: IDLE -> SETTLE -> DWELL -> (SETTLE on the next step | IDLE with done).
//  IDLE:
//   - start=1 at edge T latches mode and dwell (0->1), sets step_idx=0 and signature=32'hFFFF_FFFF.
//   - At T+1: busy=1 and pwr_en_out=pattern(0).
//  SETTLE:
//   - Lasts exactly SETTLE_CYCLES cycles; the MISR holds.
//  DWELL:
//   - Lasts exactly dwell cycles; on each cycle the MISR updates.
//   - On the last DWELL cycle, if step_idx < NSTEPS-1: step_idx++, pwr_en_out=pattern(step_idx+1), go to SETTLE.
//   - Otherwise: pwr_en_out=0, busy=0, done=1 for one cycle, go to IDLE.
//  Patterns, with k = step_idx:
//   - ramp: low k bits set; NSTEPS=NUM_MODULES+1, so k=0 gives all-off and k=NUM_MODULES gives all-on.
//   - walking-one: only bit k set; NSTEPS=NUM_MODULES.
//   - all-on: all ones; NSTEPS=1.
//   - all-off: all zeros; NSTEPS=1.
//  Step duration is SETTLE_CYCLES+dwell cycles; done rises at T+1+NSTEPS*(SETTLE_CYCLES+dwell).
//  MISR update: sig <= {sig[30:0], sig[31]^sig[21]^sig[1]^sig[0]} ^ zext32(dummy_in); polynomial x^32+x^22+x^2+x+1.
//  Dwell counter: counts 0..dwell-1 and compares at dwell-1; the full DWELL_W range is legal, no wrap inside a step.
//  start while busy: ignored; latched values and signature are unaffected.
//  start in the same cycle as done: ignored; a new start must arrive in IDLE after done.
//  mode/dwell_cycles changes while busy: no effect.
//  rst mid-sequence: all registers take reset values next edge; pwr_en_out drops to 0 at once; no done pulse.
// STRUCTURE
//  Package pwr_seq_pkg holds:
//   - mode encodings MODE_RAMP/MODE_WALK/MODE_ALLON/MODE_ALLOFF;
//   - FSM state encodings S_IDLE/S_SETTLE/S_DWELL;
//   - MISR_POLY and MISR_SEED=32'hFFFF_FFFF.
//  One sub-module, misr32: ports clk100m, rst, clr, en, din[31:0], sig[31:0]; clr loads the seed and has priority over en.
//  The top level holds the FSM, the step/dwell/settle counters and the pattern generation.
// TESTING
//  1. Reset: hold rst 3 cycles -> pwr_en_out=0, busy=0, done=0, signature=FFFF_FFFF; then start with rst=1 -> still IDLE.
//  2. All-on, dwell=10, start at T:
//     - pwr_en_out=FFFF_FFFF over T+1..T+14;
//     - done=1 only at T+15 with pwr_en_out=0;
//     - signature equals the model after 10 updates with dummy_in=FFFF_FFFF.
//  3. Walking-one, dwell=1:
//     - 32 steps;
//     - pwr_en_out=1<<k for 5 cycles each;
//     - step_idx runs 0..31;
//     - done at T+1+32*5=T+161.
//  4. Ramp, dwell=0 (treated as 1):
//     - 33 steps;
//     - step 0 gives 0000_0000, step 32 gives FFFF_FFFF;
//     - done at T+166.
//  5. Second start pulse mid-sequence with different mode/dwell -> ignored, timing and signature unchanged.
//  6. rst asserted during DWELL of step 3 -> next edge: all reset values, no done pulse; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/pwr_seq_pkg.sv
// Shared encodings for the power-enable sequencer: enable-pattern modes,
// FSM states and the MISR feedback/seed constants.
package pwr_seq_pkg;

    // Enable-pattern modes, as presented on the mode input
    localparam logic [1:0] MODE_RAMP   = 2'd0;
    localparam logic [1:0] MODE_WALK   = 2'd1;
    localparam logic [1:0] MODE_ALLON  = 2'd2;
    localparam logic [1:0] MODE_ALLOFF = 2'd3;

    // Sequencer FSM states
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_SETTLE = 2'd1;
    localparam logic [1:0] S_DWELL  = 2'd2;

    // Feedback tap mask for x^32+x^22+x^2+x+1 in a left-shifting register:
    // the new LSB is the XOR of bits 31, 21, 1 and 0.
    localparam logic [31:0] MISR_POLY = 32'h8020_0003;
    localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

endpackage

// File: rtl/pwr_en_sequencer_misr32.sv
// 32-bit multiple-input signature register. clr reloads the seed and wins
// over en; with en low the signature holds.
module misr32
    import pwr_seq_pkg::*;
(
    input  logic        clk100m,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [31:0] din,
    output logic [31:0] sig
);

    // Signature register: seed on reset/clear, shift-and-fold when enabled
    always_ff @(posedge clk100m) begin
        if (rst || clr) begin
            sig <= MISR_SEED;
        end else if (en) begin
            sig <= {sig[30:0], ^(sig & MISR_POLY)} ^ din;
        end
    end

endmodule

// File: rtl/pwr_en_sequencer.sv
// Power-enable sequencer: steps the DUT array through an enable pattern,
// lets each step settle, then folds the returned dummy bits into a MISR.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  S_IDLE   | waiting for start; outputs parked, signature held
//  S_SETTLE | new pattern applied, waiting out the DUT array pipeline
//  S_DWELL  | MISR captures dummy_in every cycle for the dwell time
module pwr_en_sequencer
    import pwr_seq_pkg::*;
#(
    parameter int NUM_MODULES   = 32,
    parameter int DWELL_W       = 32,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic                   clk100m,
    input  logic                   rst,
    input  logic                   start,
    input  logic [1:0]             mode,
    input  logic [DWELL_W-1:0]     dwell_cycles,
    output logic [NUM_MODULES-1:0] pwr_en_out,
    input  logic [NUM_MODULES-1:0] dummy_in,
    output logic                   busy,
    output logic                   done,
    output logic [5:0]             step_idx,
    output logic [31:0]            signature
);

    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);

    logic [1:0]         state;
    logic [1:0]         mode_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] dwell_cnt;
    logic [SET_W-1:0]   settle_cnt;
    logic               accept;
    logic               last_step;
    logic [31:0]        din_ext;

    // Enable vector for step k of the given mode
    function automatic logic [NUM_MODULES-1:0] pattern(input logic [1:0] m,
                                                       input logic [5:0] k);
        logic [NUM_MODULES-1:0] p;
        p = '0;
        for (int i = 0; i < NUM_MODULES; i++) begin
            case (m)
                MODE_RAMP:   p[i] = (6'(i) < k);
                MODE_WALK:   p[i] = (6'(i) == k);
                MODE_ALLON:  p[i] = 1'b1;
                MODE_ALLOFF: p[i] = 1'b0;
                default:     p[i] = 1'b0;
            endcase
        end
        return p;
    endfunction

    // Index of the final step of a mode (ramp has one extra all-on step)
    function automatic logic [5:0] last_idx(input logic [1:0] m);
        case (m)
            MODE_RAMP: return 6'(NUM_MODULES);
            MODE_WALK: return 6'(NUM_MODULES - 1);
            default:   return 6'd0;
        endcase
    endfunction

    // A start arriving alongside the done pulse is deliberately dropped
    assign accept    = (state == S_IDLE) && start && !done;
    assign last_step = (step_idx == last_idx(mode_q));

    // Zero-extend the returned dummy bits to the MISR width
    always_comb begin
        din_ext                  = '0;
        din_ext[NUM_MODULES-1:0] = dummy_in;
    end

    // Sequencer FSM, step/settle/dwell counters and enable-pattern register
    always_ff @(posedge clk100m) begin
        if (rst) begin
            state      <= S_IDLE;
            mode_q     <= MODE_RAMP;
            dwell_q    <= '0;
            dwell_cnt  <= '0;
            settle_cnt <= '0;
            step_idx   <= '0;
            pwr_en_out <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        mode_q     <= mode;
                        dwell_q    <= (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
                        step_idx   <= '0;
                        pwr_en_out <= pattern(mode, 6'd0);
                        busy       <= 1'b1;
                        settle_cnt <= '0;
                        dwell_cnt  <= '0;
                        state      <= S_SETTLE;
                    end
                end
                S_SETTLE: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        dwell_cnt  <= '0;
                        state      <= S_DWELL;
                    end else begin
                        settle_cnt <= settle_cnt + SET_W'(1);
                    end
                end
                S_DWELL: begin
                    if (dwell_cnt == dwell_q - DWELL_W'(1)) begin
                        dwell_cnt <= '0;
                        if (!last_step) begin
                            step_idx   <= step_idx + 6'd1;
                            pwr_en_out <= pattern(mode_q, step_idx + 6'd1);
                            state      <= S_SETTLE;
                        end else begin
                            pwr_en_out <= '0;
                            busy       <= 1'b0;
                            done       <= 1'b1;
                            state      <= S_IDLE;
                        end
                    end else begin
                        dwell_cnt <= dwell_cnt + DWELL_W'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    misr32 u_misr (
        .clk100m (clk100m),
        .rst     (rst),
        .clr     (accept),
        .en      (state == S_DWELL),
        .din     (din_ext),
        .sig     (signature)
    );

endmodule
